// File: rtl/gate_input_debouncer.sv
// Two-channel pad conditioner: 2-flop sync, per-channel debounce, optional inversion, sticky warm-up valid.
// Define EDGE_PULSE_EN to add registered rise/fall pulse outputs per channel.
module gate_input_debouncer #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3,
    parameter logic [1:0]  INVERT_MASK   = 2'b00
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [1:0] raw_in,
    output logic       input1,
    output logic       input2,
    output logic       valid
`ifdef EDGE_PULSE_EN
    ,
    output logic [1:0] rise,
    output logic [1:0] fall
`endif
);

    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

    generate
        if (STABLE_CYCLES == 0 || STABLE_CYCLES > CNT_MAX) begin : g_param_check
            $error("gate_input_debouncer: STABLE_CYCLES must be in 1..2^CNT_W-1");
        end
    endgenerate

    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            state_q, state_d;
    logic [1:0]            out_q, out_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]      warm_q, warm_d;
    logic                  valid_q, valid_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        warm_d  = warm_q;
        valid_d = valid_q;
        if (tick) begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == state_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == TERM) begin
                    state_d[i] = ~state_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            // warm-up saturates at its terminal count; valid is sticky from then on
            if (warm_q == TERM) begin
                valid_d = 1'b1;
            end else begin
                warm_d = warm_q + 1'b1;
            end
        end
        // outputs come straight from a flop so the gate network never sees a glitch
        out_d = state_d ^ INVERT_MASK;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= '0;
            cnt_q   <= '0;
            warm_q  <= '0;
            valid_q <= 1'b0;
            out_q   <= INVERT_MASK;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign input1 = out_q[0];
    assign input2 = out_q[1];
    assign valid  = valid_q;

`ifdef EDGE_PULSE_EN
    logic [1:0] rise_q, rise_d;
    logic [1:0] fall_q, fall_d;

    always_comb begin
        rise_d = state_d & ~state_q;
        fall_d = ~state_d & state_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    // level outputs only
`endif

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Self-checking bench for gate_input_debouncer: directed scenarios plus randomized traffic
// compared against a sliding-window reference model of the debounce rule.
module tb_gate_input_debouncer;

    localparam int unsigned SC   = 4;
    localparam int unsigned CW   = 3;
    localparam logic [1:0]  MASK = 2'b10;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tick;
    logic [1:0] raw_in;
    logic       input1, input2, valid;
`ifdef EDGE_PULSE_EN
    logic [1:0] rise, fall;
`endif

    int errors = 0;
    int checks = 0;

    gate_input_debouncer #(
        .STABLE_CYCLES(SC),
        .CNT_W        (CW),
        .INVERT_MASK  (MASK)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .tick   (tick),
        .raw_in (raw_in),
        .input1 (input1),
        .input2 (input2),
        .valid  (valid)
`ifdef EDGE_PULSE_EN
        ,
        .rise   (rise),
        .fall   (fall)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: a level is accepted once the last SC tick-edge samples of the
    // synchronised input all disagree with the held level.
    logic [1:0] m_s1 = '0, m_s2 = '0, m_state = '0;
    logic [1:0] m_rise = '0, m_fall = '0;
    int         m_warm = 0;
    logic [1:0] hist[$];
    bit         all_diff;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_state = '0; m_warm = 0;
            m_rise = '0; m_fall = '0;
            hist.delete();
        end else begin
            m_rise = '0; m_fall = '0;
            if (tick) begin
                hist.push_back(m_s2);
                if (hist.size() > SC) void'(hist.pop_front());
                m_warm++;
                for (int ch = 0; ch < 2; ch++) begin
                    if (hist.size() == SC) begin
                        all_diff = 1'b1;
                        foreach (hist[j]) if (hist[j][ch] == m_state[ch]) all_diff = 1'b0;
                        if (all_diff) begin
                            if (m_state[ch]) m_fall[ch] = 1'b1; else m_rise[ch] = 1'b1;
                            m_state[ch] = ~m_state[ch];
                        end
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw_in;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; tick = 1'b1; raw_in = 2'b00;
        repeat (3) @(negedge clock);
        checks++; if (input1 !== 1'b0) begin errors++; $display("FAIL reset_input1 got=%b exp=0", input1); end
        checks++; if (input2 !== 1'b1) begin errors++; $display("FAIL reset_input2 got=%b exp=1", input2); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        reset_n = 1'b1;
        for (int m = 1; m <= 5; m++) begin
            @(negedge clock);
            checks++;
            if (valid !== ((m >= 4) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL warmup_valid edge=%0d got=%b exp=%b", m, valid, (m >= 4));
            end
        end
    endtask

    task automatic test_latency();
        raw_in = 2'b01;
        for (int m = 1; m <= 6; m++) begin
            @(negedge clock);
            checks++;
            if (input1 !== ((m >= 6) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL latency_input1 edge=%0d got=%b exp=%b", m, input1, (m >= 6));
            end
            checks++;
            if (input2 !== 1'b1) begin errors++; $display("FAIL latency_input2 edge=%0d got=%b exp=1", m, input2); end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] pat;
        pat = 4'b0111;
        raw_in = 2'b00;
        repeat (8) @(negedge clock);
        checks++; if (input1 !== 1'b0) begin errors++; $display("FAIL bounce_settle got=%b exp=0", input1); end
        for (int i = 0; i < 4; i++) begin
            raw_in[0] = pat[i];
            @(negedge clock);
            checks++; if (input1 !== 1'b0) begin errors++; $display("FAIL bounce_hold step=%0d got=%b exp=0", i, input1); end
        end
        raw_in[0] = 1'b1;
        for (int m = 1; m <= 7; m++) begin
            @(negedge clock);
            checks++;
            if (input1 !== ((m >= 6) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL bounce_rise edge=%0d got=%b exp=%b", m, input1, (m >= 6));
            end
        end
    endtask

    task automatic test_tick_gating();
        int flip_c;
        flip_c = -1;
        raw_in = 2'b11;
        for (int c = 0; c < 40; c++) begin
            tick = ((c % 4) == 3) ? 1'b1 : 1'b0;
            @(negedge clock);
            checks++;
            if (input2 !== (m_state[1] ^ MASK[1])) begin
                errors++; $display("FAIL tick_input2 cyc=%0d got=%b exp=%b", c, input2, m_state[1] ^ MASK[1]);
            end
            if (input2 === 1'b0 && flip_c < 0) flip_c = c;
        end
        tick = 1'b1;
        checks++;
        if (flip_c != 15) begin errors++; $display("FAIL tick_flip_cycle got=%0d exp=15", flip_c); end
    endtask

    task automatic test_async_reset();
        tick = 1'b1; raw_in = 2'b00;
        repeat (8) @(negedge clock);
        raw_in = 2'b11;
        repeat (4) @(negedge clock);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (input1 !== 1'b0) begin errors++; $display("FAIL async_input1 got=%b exp=0", input1); end
        checks++; if (input2 !== 1'b1) begin errors++; $display("FAIL async_input2 got=%b exp=1", input2); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL async_valid got=%b exp=0", valid); end
        @(negedge clock);
        reset_n = 1'b1;
        for (int m = 1; m <= 6; m++) begin
            @(negedge clock);
            checks++;
            if (input1 !== ((m >= 6) ? 1'b1 : 1'b0) || input2 !== ((m >= 6) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL post_reset_outs edge=%0d got=%b%b exp=%b%b", m, input2, input1, (m < 6), (m >= 6));
            end
            checks++;
            if (valid !== ((m >= 4) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL post_reset_valid edge=%0d got=%b exp=%b", m, valid, (m >= 4));
            end
        end
    endtask

`ifdef EDGE_PULSE_EN
    task automatic test_edge_pulse();
        tick = 1'b1; raw_in = 2'b00;
        repeat (10) @(negedge clock);
        raw_in = 2'b11;
        for (int m = 1; m <= 8; m++) begin
            @(negedge clock);
            checks++;
            if (rise !== ((m == 6) ? 2'b11 : 2'b00) || fall !== 2'b00) begin
                errors++; $display("FAIL edge_rise edge=%0d rise=%b fall=%b", m, rise, fall);
            end
        end
        raw_in = 2'b00;
        for (int m = 1; m <= 8; m++) begin
            @(negedge clock);
            checks++;
            if (fall !== ((m == 6) ? 2'b11 : 2'b00) || rise !== 2'b00) begin
                errors++; $display("FAIL edge_fall edge=%0d rise=%b fall=%b", m, rise, fall);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 2; b++) if ($urandom_range(0, 5) == 0) raw_in[b] = ~raw_in[b];
            tick = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            @(negedge clock);
            checks++;
            if (input1 !== (m_state[0] ^ MASK[0]) || input2 !== (m_state[1] ^ MASK[1])) begin
                errors++; $display("FAIL random_outs cyc=%0d got=%b%b exp=%b", c, input2, input1, m_state ^ MASK);
            end
            checks++;
            if (valid !== ((m_warm >= SC) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL random_valid cyc=%0d got=%b exp=%b", c, valid, (m_warm >= SC));
            end
`ifdef EDGE_PULSE_EN
            checks++;
            if (rise !== m_rise || fall !== m_fall) begin
                errors++; $display("FAIL random_edges cyc=%0d rise=%b/%b fall=%b/%b", c, rise, m_rise, fall, m_fall);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_tick_gating();
        test_async_reset();
`ifdef EDGE_PULSE_EN
        test_edge_pulse();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout no completion by 200000");
        $fatal(1, "timeout");
    end

endmodule
